// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter.
// Holds the per-byte serialiser state encoding and the default
// parameter values used by uart_frame_tx, uart_byte_tx and the frame
// interface. No ports.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int          DEF_CLK_DIV   = 434;
  localparam int          DEF_N_BYTES   = 10;
  localparam logic [7:0]  DEF_HDR_BYTE  = 8'hFF;
  localparam int          DEF_STOP_BITS = 2;
  localparam int          DEF_CSUM_EN   = 1;

endpackage

// File: rtl/uart_frame_tx_if.sv
// Frame handshake bundle between a payload producer and uart_frame_tx.
// Signals:
//   frame_data  [8*N_BYTES-1:0]  payload, byte k in bits [8k+7:8k]
//   frame_valid                  producer has a payload
//   frame_ready                  transmitter accepts a payload this cycle
// Modports: master (producer side), slave (transmitter side).
// N_BYTES must match the N_BYTES of the attached uart_frame_tx.
interface uart_frame_tx_if
  import uart_pkg::*;
#(
  parameter int N_BYTES = DEF_N_BYTES
) ();

  logic [8*N_BYTES-1:0] frame_data;
  logic                 frame_valid;
  logic                 frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/uart_byte_tx.sv
// Single-byte UART serialiser: start bit, 8 data bits LSB first, then
// STOP_BITS stop bits, each held CLK_DIV cycles.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   i_start  load i_byte and begin a byte (honoured in IDLE, and on the
//            final cycle of the last stop bit for back-to-back bytes)
//   i_byte   byte to send
//   o_tx     registered serial line, idle high
//   o_done   high on the final cycle of the last stop bit
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_done
);

  localparam int CNT_W = $clog2(CLK_DIV);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [2:0]         r_bit,   w_bit_nxt;
  logic [7:0]         r_sh,    w_sh_nxt;
  logic               r_tx,    w_tx_nxt;
  logic               w_period_end;

  assign w_period_end = (r_cnt == CNT_W'(CLK_DIV - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_sh_nxt    = r_sh;
    w_tx_nxt    = r_tx;
    o_done      = 1'b0;

    if (r_state != IDLE) begin
      w_cnt_nxt = w_period_end ? '0 : r_cnt + CNT_W'(1);
    end

    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (i_start) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_sh_nxt    = i_byte;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_period_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_sh[0];
          w_sh_nxt    = {1'b0, r_sh[7:1]};
        end
      end
      DATA: begin
        if (w_period_end) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_sh[0];
            w_sh_nxt  = {1'b0, r_sh[7:1]};
          end
        end
      end
      STOP: begin
        if (w_period_end) begin
          if (r_bit == 3'(STOP_BITS - 1)) begin
            o_done = 1'b1;
            // A start request here chains the next byte with no gap.
            if (i_start) begin
              w_state_nxt = START;
              w_bit_nxt   = '0;
              w_sh_nxt    = i_byte;
              w_tx_nxt    = 1'b0;
            end else begin
              w_state_nxt = IDLE;
              w_bit_nxt   = '0;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Shift register holds only data; its contents are irrelevant in IDLE.
  always_ff @(posedge clk) begin
    r_sh <= w_sh_nxt;
  end

  assign o_tx = r_tx;

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: on accepting a payload it sends HDR_BYTE twice,
// the N_BYTES payload bytes (byte 0 first) and, if CSUM_EN, a mod-256
// checksum of the payload, back to back with no idle gaps.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset; aborts a frame in progress
//   s_frm     frame handshake (frame_data, frame_valid in; frame_ready out)
//   rs232_tx  registered serial output, idle high
//   busy      a frame is being transmitted (inverse of frame_ready)
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int         CLK_DIV   = DEF_CLK_DIV,
  parameter int         N_BYTES   = DEF_N_BYTES,
  parameter logic [7:0] HDR_BYTE  = DEF_HDR_BYTE,
  parameter int         STOP_BITS = DEF_STOP_BITS,
  parameter int         CSUM_EN   = DEF_CSUM_EN
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_frame_tx_if.slave  s_frm,
  output logic            rs232_tx,
  output logic            busy
);

  localparam int N_TOTAL = 2 + N_BYTES + CSUM_EN;
  localparam int IDX_W   = $clog2(N_TOTAL);

  logic                 r_active;
  logic [IDX_W-1:0]     r_idx;
  logic [8*N_BYTES-1:0] r_data;

  logic                 w_accept;
  logic                 w_done;
  logic                 w_last;
  logic                 w_start;
  logic [IDX_W-1:0]     w_next_idx;
  logic [7:0]           w_byte;
  logic [7:0]           w_csum;

  function automatic logic [7:0] csum8(input logic [8*N_BYTES-1:0] d);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < N_BYTES; k++) begin
      s = s + d[8*k +: 8];
    end
    return s;
  endfunction

  assign s_frm.frame_ready = ~r_active;
  assign busy              = r_active;

  assign w_accept   = s_frm.frame_valid & ~r_active;
  assign w_last     = (r_idx == IDX_W'(N_TOTAL - 1));
  // The serialiser is restarted either by a new frame or when a byte
  // finishes and more bytes remain.
  assign w_start    = w_accept | (w_done & ~w_last);
  assign w_next_idx = w_accept ? '0 : r_idx + IDX_W'(1);
  assign w_csum     = csum8(r_data);

  // Headers are never data-dependent, so the first byte can be chosen
  // on the accept cycle before r_data has been loaded.
  always_comb begin
    w_byte = w_csum;
    if (w_next_idx < IDX_W'(2)) begin
      w_byte = HDR_BYTE;
    end
    for (int k = 0; k < N_BYTES; k++) begin
      if (w_next_idx == IDX_W'(k + 2)) begin
        w_byte = r_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_idx    <= '0;
    end else if (w_accept) begin
      r_active <= 1'b1;
      r_idx    <= '0;
    end else if (w_done) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_idx    <= '0;
      end else begin
        r_idx <= w_next_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data <= s_frm.frame_data;
    end
  end

  uart_byte_tx #(
    .CLK_DIV   (CLK_DIV),
    .STOP_BITS (STOP_BITS)
  ) u_byte_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_byte  (w_byte),
    .o_tx    (rs232_tx),
    .o_done  (w_done)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;

  typedef logic [7:0] bq_t[$];

  logic clk;
  logic rst_n;
  logic txa, busya, txb, busyb;
  int   checks;
  int   errors;

  uart_frame_tx_if #(.N_BYTES(2)) ifa ();
  uart_frame_tx_if #(.N_BYTES(1)) ifb ();

  uart_frame_tx #(
    .CLK_DIV(4), .N_BYTES(2), .HDR_BYTE(8'hFF), .STOP_BITS(2), .CSUM_EN(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .s_frm(ifa), .rs232_tx(txa), .busy(busya)
  );

  uart_frame_tx #(
    .CLK_DIV(4), .N_BYTES(1), .HDR_BYTE(8'hFF), .STOP_BITS(1), .CSUM_EN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .s_frm(ifb), .rs232_tx(txb), .busy(busyb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the byte sequence a frame must carry on the line.
  function automatic bq_t model(input logic [15:0] d, input int n, input int cs);
    bq_t q;
    int  sum;
    q.push_back(8'hFF);
    q.push_back(8'hFF);
    sum = 0;
    for (int k = 0; k < n; k++) begin
      q.push_back(d[8*k +: 8]);
      sum = sum + int'(d[8*k +: 8]);
    end
    if (cs != 0) q.push_back(8'(sum % 256));
    return q;
  endfunction

  task automatic set_data(input int sel, input logic [15:0] d);
    if (sel == 1) ifb.frame_data = d[7:0];
    else          ifa.frame_data = d;
  endtask

  task automatic set_valid(input int sel, input logic v);
    if (sel == 1) ifb.frame_valid = v;
    else          ifa.frame_valid = v;
  endtask

  task automatic send(input int sel, input logic [15:0] d, input string tag);
    @(negedge clk);
    set_data(sel, d);
    set_valid(sel, 1'b1);
    chk({tag, "_ready_before"}, (sel == 1) ? ifb.frame_ready : ifa.frame_ready, 1);
  endtask

  // Follows one frame cycle by cycle from the cycle after the accept edge,
  // comparing the line against the ideal waveform built from the byte list.
  task automatic watch(input int sel, input logic [15:0] d, input bit hold,
                       input int chg_cyc, input logic [15:0] chg_d,
                       input int rst_cyc, input string tag);
    bq_t        exp;
    logic [7:0] dec [0:7];
    logic [7:0] eb;
    logic       ebit, tx, bz;
    int         cdiv, sb, n, cs, nb, bper, len, mism, busy_n, t, b, p;
    bit         aborted;
    cdiv = 4;
    sb   = (sel == 1) ? 1 : 2;
    n    = (sel == 1) ? 1 : 2;
    cs   = (sel == 1) ? 0 : 1;
    exp  = model(d, n, cs);
    nb   = exp.size();
    bper = 9 + sb;
    len  = nb * bper * cdiv;
    mism = 0;
    busy_n = 0;
    aborted = 1'b0;
    for (int i = 0; i < 8; i++) dec[i] = 8'h00;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) set_valid(sel, 1'b0);
      t  = c - 1;
      b  = t / (bper * cdiv);
      p  = (t / cdiv) % bper;
      eb = exp[b];
      ebit = (p == 0) ? 1'b0 : (p <= 8) ? eb[p-1] : 1'b1;
      tx = (sel == 1) ? txb : txa;
      bz = (sel == 1) ? busyb : busya;
      if (tx !== ebit) mism++;
      if (bz === 1'b1) busy_n++;
      if ((t % cdiv) == (cdiv / 2) && p >= 1 && p <= 8) dec[b][p-1] = tx;
      if (c == chg_cyc) set_data(sel, chg_d);
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_tx"}, (sel == 1) ? txb : txa, 1);
        chk({tag, "_rst_ready"}, (sel == 1) ? ifb.frame_ready : ifa.frame_ready, 1);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    chk({tag, "_wave_mism"}, mism, 0);
    if (!aborted) begin
      for (int k = 0; k < nb; k++) chk($sformatf("%s_byte%0d", tag, k), dec[k], exp[k]);
      chk({tag, "_len"}, busy_n, len);
      @(negedge clk);
      chk({tag, "_idle_tx"}, (sel == 1) ? txb : txa, 1);
      chk({tag, "_idle_ready"}, (sel == 1) ? ifb.frame_ready : ifa.frame_ready, 1);
      chk({tag, "_idle_busy"}, (sel == 1) ? busyb : busya, 0);
    end
  endtask

  initial begin
    logic [15:0] r;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ifa.frame_valid = 1'b0;
    ifa.frame_data  = '0;
    ifb.frame_valid = 1'b0;
    ifb.frame_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", txa, 1);
    chk("rst_ready_a", ifa.frame_ready, 1);
    chk("rst_busy_a", busya, 0);
    chk("rst_tx_b", txb, 1);
    chk("rst_ready_b", ifb.frame_ready, 1);
    chk("rst_busy_b", busyb, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 16'h1234: FF FF 34 12 46 in 220 cycles.
    send(0, 16'h1234, "single");
    watch(0, 16'h1234, 1'b0, 0, 16'h0, 0, "single");

    // Checksum wraps: F0 + 20 -> 10.
    send(0, 16'h20F0, "wrap");
    watch(0, 16'h20F0, 1'b0, 0, 16'h0, 0, "wrap");

    // Valid held high and data changed mid-frame: first frame keeps the
    // original payload, second is accepted after exactly one idle cycle.
    send(0, 16'hBEEF, "ign1");
    watch(0, 16'hBEEF, 1'b1, 30, 16'h5A3C, 0, "ign1");
    watch(0, 16'h5A3C, 1'b0, 0, 16'h0, 0, "ign2");

    // Reset at cycle 50 of a frame, then a clean frame.
    send(0, 16'hC3A1, "rstmid");
    watch(0, 16'hC3A1, 1'b0, 0, 16'h0, 50, "rstmid");
    @(negedge clk);
    chk("post_rst_busy", busya, 0);
    send(0, 16'h0F81, "after_rst");
    watch(0, 16'h0F81, 1'b0, 0, 16'h0, 0, "after_rst");

    // Variant configuration: FF FF A5 in 120 cycles.
    send(1, 16'h00A5, "cfgb");
    watch(1, 16'h00A5, 1'b0, 0, 16'h0, 0, "cfgb");

    // Randomized payloads on both configurations with random idle gaps.
    for (int i = 0; i < 4; i++) begin
      r = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, r, $sformatf("rnda%0d", i));
      watch(0, r, 1'b0, 0, 16'h0, 0, $sformatf("rnda%0d", i));
      r = 16'($urandom);
      send(1, r, $sformatf("rndb%0d", i));
      watch(1, {8'h00, r[7:0]}, 1'b0, 0, 16'h0, 0, $sformatf("rndb%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter CLK_DIV, default 434: clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter N_BYTES, default 10: payload bytes per frame; legal range 1..32.
REQ-003 Parameter HDR_BYTE, default 8'hFF: sync byte, sent twice at frame start.
REQ-004 Parameter STOP_BITS, default 2: stop bits per byte; legal values 1 or 2.
REQ-005 Parameter CSUM_EN, default 1: when 1, one checksum byte is appended after the payload.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 Port frame_data, input, 8*N_BYTES bits: payload; byte k is bits [8k+7:8k].
REQ-009 Port frame_valid, input, 1 bit: payload available.
REQ-010 Port frame_ready, output, 1 bit: block accepts a frame this cycle.
REQ-011 Port rs232_tx, output, 1 bit: serial line; idle level is high.
REQ-012 Port busy, output, 1 bit: a frame is in transmission.

Function
REQ-013 Handshake: a frame is accepted on a cycle with frame_valid=1 and frame_ready=1; frame_data is latched into an internal register on that cycle.
REQ-014 frame_ready = 1 only in IDLE; busy = NOT frame_ready.
REQ-015 Byte order on the line: HDR_BYTE, HDR_BYTE, payload byte 0 .. byte N_BYTES-1, then the checksum byte if CSUM_EN=1.
REQ-016 Checksum = mod-256 sum of the N_BYTES latched payload bytes; headers are excluded.
REQ-017 Byte format: 1 start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1); each bit is held exactly CLK_DIV cycles.
REQ-018 Byte FSM states and transitions: IDLE -> START -> DATA(8 bits) -> STOP -> START of the next byte, or -> IDLE after the last byte.
REQ-019 Latency: rs232_tx goes low on the first cycle after the accept cycle.
REQ-020 Frame length is exactly (2+N_BYTES+CSUM_EN)*(9+STOP_BITS)*CLK_DIV cycles; there are no idle gaps between bytes.
REQ-021 After the last stop bit, the block spends at least 1 IDLE cycle (frame_ready=1) before the next start bit.
REQ-022 While busy, frame_valid and frame_data changes are ignored; the latched payload is used.
REQ-023 The bit-period counter and the byte/bit indices wrap to 0 at each boundary; the byte index never exceeds 2+N_BYTES+CSUM_EN-1.
REQ-024 rs232_tx is driven from a flop and is glitch-free.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, rs232_tx=1, frame_ready=1, busy=0, and all counters=0.
REQ-026 Reset mid-frame aborts the frame: rs232_tx=1 on the cycle after the reset edge, and no partial byte is resumed.
REQ-027 The latched payload register does not require a reset.

Structure
REQ-028 A shared package uart_pkg holds the state enum (IDLE, START, DATA, STOP) and the default parameter constants.
REQ-029 One sub-module uart_byte_tx (CLK_DIV, STOP_BITS) serialises a single byte with a start/done handshake.
REQ-030 uart_frame_tx sequences the bytes and computes the checksum.

Verification
REQ-031 Scenario, single frame: CLK_DIV=4, N_BYTES=2, STOP_BITS=2, CSUM_EN=1, frame_data=16'h1234 -> bytes FF FF 34 12 46 decoded; frame lasts 220 cycles.
REQ-032 Scenario, checksum wrap: bytes 8'hF0, 8'h20 -> checksum byte 8'h10.
REQ-033 Scenario, ignored input: frame_valid held high and frame_data changed mid-frame -> the frame carries the original data, and a second frame starts 1 IDLE cycle after the first ends.
REQ-034 Scenario, reset mid-frame: rst_n=0 at cycle 50 of a frame -> rs232_tx=1 and frame_ready=1 on the next cycle; the next accepted frame is correct.
REQ-035 Scenario, configuration variant: STOP_BITS=1, CSUM_EN=0, N_BYTES=1, data 8'hA5 -> bytes FF FF A5 decoded; frame lasts 3*10*CLK_DIV cycles.
REQ-036 Scenario, bit timing: every bit period measures exactly CLK_DIV cycles, and the first start bit begins 1 cycle after the accept cycle.
